row_window_stream: RTL

ROW_WINDOW_STREAM -- requirements
Module: row_window_stream

---
 rtl/row_window_stream.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/row_window_stream.sv
// row_window_stream
//   Converts a raster-order pixel stream into vertical window columns of
//   KERNEL_SIZE pixels. KERNEL_SIZE-1 line banks hold the previous rows.
//   Each accepted pixel is emitted together with the pixels directly above
//   it, oldest row in the LSB slice and the current pixel in the MSB slice.
//
// Optional feature:
//   ROW_WINDOW_ZERO_PAD_EN - when defined, every accepted pixel produces an
//   output column. Rows not yet filled in the current frame read as zero.
//   When undefined, columns are produced only once all banks hold rows of
//   the current frame.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   cfg_width/cfg_height frame geometry, sampled on pixel (0,0) of each frame
//   s_valid/s_ready/s_data  pixel input handshake
//   m_valid/m_ready      window-column output handshake
//   m_col                window column (slice 0 = oldest row)
//   m_eol/m_last         column ends its row / ends the frame
//   cfg_err              sticky flag for an invalid sampled geometry
module row_window_stream #(
    parameter int PIXEL_BITS  = 8,
    parameter int MAX_WIDTH   = 512,
    parameter int KERNEL_SIZE = 5,
    parameter int MAX_HEIGHT  = 512
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [$clog2(MAX_WIDTH+1)-1:0]      cfg_width,
    input  logic [$clog2(MAX_HEIGHT+1)-1:0]     cfg_height,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [PIXEL_BITS-1:0]               s_data,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [PIXEL_BITS*KERNEL_SIZE-1:0]   m_col,
    output logic                                m_eol,
    output logic                                m_last,
    output logic                                cfg_err
);

    localparam int RB_COUNT = KERNEL_SIZE - 1;
    localparam int WW = $clog2(MAX_WIDTH + 1);
    localparam int HW = $clog2(MAX_HEIGHT + 1);
    localparam int XW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int YW = (MAX_HEIGHT > 1) ? $clog2(MAX_HEIGHT) : 1;
    localparam int BW = (RB_COUNT > 1) ? $clog2(RB_COUNT) : 1;
    localparam int FW = $clog2(RB_COUNT + 1);
    localparam int CW = PIXEL_BITS * KERNEL_SIZE;

    // Line banks; contents are intentionally not reset.
    logic [PIXEL_BITS-1:0] bank_mem [RB_COUNT][MAX_WIDTH];

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [BW-1:0] wb_q, wb_d;
    logic [FW-1:0] f_q, f_d;
    logic [WW-1:0] width_q, width_d;
    logic [HW-1:0] height_q, height_d;
    logic          cfg_err_q, cfg_err_d;
    logic          m_valid_q, m_valid_d;
    logic          m_eol_q, m_eol_d;
    logic          m_last_q, m_last_d;
    logic [CW-1:0] m_col_q, m_col_d;

    logic          frame_start;
    logic [WW-1:0] width_eff;
    logic [HW-1:0] height_eff;
    logic          cfg_bad;
    logic          accept;
    logic          take;
    logic          end_of_row;
    logic          end_of_frame;
    logic          produce;
    logic [CW-1:0] col_next;

    assign s_ready = (!m_valid_q || m_ready) && !cfg_err_q;
    assign m_valid = m_valid_q;
    assign m_col   = m_col_q;
    assign m_eol   = m_eol_q;
    assign m_last  = m_last_q;
    assign cfg_err = cfg_err_q;

    // Geometry comes straight from the inputs on pixel (0,0) so the first
    // pixel of a frame already uses the new values.
    always_comb begin
        frame_start  = (x_q == '0) && (y_q == '0);
        width_eff    = frame_start ? cfg_width  : width_q;
        height_eff   = frame_start ? cfg_height : height_q;
        cfg_bad      = frame_start &&
                       ((cfg_width  < WW'(2)) || (cfg_width  > WW'(MAX_WIDTH)) ||
                        (cfg_height < HW'(1)) || (cfg_height > HW'(MAX_HEIGHT)));
        accept       = s_valid && s_ready;
        take         = accept && !cfg_bad;
        end_of_row   = (WW'(x_q) == (width_eff - WW'(1)));
        end_of_frame = end_of_row && (HW'(y_q) == (height_eff - HW'(1)));
`ifdef ROW_WINDOW_ZERO_PAD_EN
        produce      = 1'b1;
`else
        produce      = (f_q == FW'(RB_COUNT));
`endif
    end

    // Slice i reads bank (wb+i) mod RB_COUNT, so slice 0 is the oldest row.
    always_comb begin
        col_next = '0;
        for (int unsigned i = 0; i < RB_COUNT; i++) begin
`ifdef ROW_WINDOW_ZERO_PAD_EN
            if (int'(i) + int'(f_q) >= RB_COUNT)
                col_next[i*PIXEL_BITS +: PIXEL_BITS] =
                    bank_mem[BW'((int'(wb_q) + int'(i)) % RB_COUNT)][x_q];
`else
            col_next[i*PIXEL_BITS +: PIXEL_BITS] =
                bank_mem[BW'((int'(wb_q) + int'(i)) % RB_COUNT)][x_q];
`endif
        end
        col_next[RB_COUNT*PIXEL_BITS +: PIXEL_BITS] = s_data;
    end

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        wb_d      = wb_q;
        f_d       = f_q;
        width_d   = width_q;
        height_d  = height_q;
        cfg_err_d = cfg_err_q;
        m_valid_d = m_valid_q;
        m_eol_d   = m_eol_q;
        m_last_d  = m_last_q;
        m_col_d   = m_col_q;

        if (m_valid_q && m_ready)
            m_valid_d = 1'b0;

        if (accept && cfg_bad)
            cfg_err_d = 1'b1;

        if (take) begin
            width_d   = width_eff;
            height_d  = height_eff;
            m_valid_d = produce;
            if (produce) begin
                m_col_d  = col_next;
                m_eol_d  = end_of_row;
                m_last_d = end_of_frame;
            end
            if (end_of_frame) begin
                x_d  = '0;
                y_d  = '0;
                wb_d = '0;
                f_d  = '0;
            end else if (end_of_row) begin
                x_d  = '0;
                y_d  = y_q + YW'(1);
                wb_d = (wb_q == BW'(RB_COUNT - 1)) ? '0 : wb_q + BW'(1);
                f_d  = (f_q == FW'(RB_COUNT)) ? f_q : f_q + FW'(1);
            end else begin
                x_d  = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q       <= '0;
            y_q       <= '0;
            wb_q      <= '0;
            f_q       <= '0;
            width_q   <= '0;
            height_q  <= '0;
            cfg_err_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_eol_q   <= 1'b0;
            m_last_q  <= 1'b0;
            m_col_q   <= '0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            wb_q      <= wb_d;
            f_q       <= f_d;
            width_q   <= width_d;
            height_q  <= height_d;
            cfg_err_q <= cfg_err_d;
            m_valid_q <= m_valid_d;
            m_eol_q   <= m_eol_d;
            m_last_q  <= m_last_d;
            m_col_q   <= m_col_d;
        end
    end

    // Written after the combinational read above, giving read-before-write.
    always_ff @(posedge clk) begin
        if (take)
            bank_mem[wb_q][x_q] <= s_data;
    end

endmodule
